// File: rtl/state_machine.sv
// PUF sweep sequencer: walks every ring-oscillator loop once per run, starting
// at a latched challenge index. Each loop is evaluated REPETITIONS times as
// reset -> enable for EVAL_TIME cycles -> store strobe.
module state_machine #(
  parameter int NUM_LOOPS        = 1280,
  parameter int REPETITIONS_BITS = 16,
  parameter int REPETITIONS      = 2,
  parameter int EVAL_TIME_BITS   = 16,
  parameter int EVAL_TIME        = 8,
  parameter int CHALLENGE_BITS   = 8,
  localparam int SEL_W           = $clog2(NUM_LOOPS - 1) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CHALLENGE_BITS-1:0] challenge,
  output logic                      done,
  output logic                      reset_puf,
  output logic [SEL_W-1:0]          select_puf,
  output logic                      enable_puf,
  output logic                      store_response_puf
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_EVAL  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Terminal values; all counter compares are exact equality.
  localparam logic [REPETITIONS_BITS-1:0] REP_LAST  = REPETITIONS_BITS'(REPETITIONS - 1);
  localparam logic [EVAL_TIME_BITS-1:0]   EVAL_LAST = EVAL_TIME_BITS'(EVAL_TIME - 1);
  localparam logic [SEL_W-1:0]            LOOP_LAST = SEL_W'(NUM_LOOPS - 1);

  state_e                      state_q, state_d;
  logic [REPETITIONS_BITS-1:0] rep_cnt_q, rep_cnt_d;
  logic [EVAL_TIME_BITS-1:0]   eval_cnt_q, eval_cnt_d;
  logic [SEL_W-1:0]            loop_cnt_q, loop_cnt_d;
  logic [SEL_W-1:0]            loop_idx_q, loop_idx_d;

  // State and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rep_cnt_q  <= '0;
      eval_cnt_q <= '0;
      loop_cnt_q <= '0;
      loop_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      eval_cnt_q <= eval_cnt_d;
      loop_cnt_q <= loop_cnt_d;
      loop_idx_q <= loop_idx_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    eval_cnt_d = eval_cnt_q;
    loop_cnt_d = loop_cnt_q;
    loop_idx_d = loop_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Out-of-range challenges start the sweep at loop 0.
          if (32'(challenge) >= 32'(NUM_LOOPS)) begin
            loop_idx_d = '0;
          end else begin
            loop_idx_d = SEL_W'(challenge);
          end
          rep_cnt_d  = '0;
          loop_cnt_d = '0;
          state_d    = ST_RST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RST: begin
        eval_cnt_d = '0;
        state_d    = ST_EVAL;
      end
      ST_EVAL: begin
        if (eval_cnt_q == EVAL_LAST) begin
          state_d = ST_STORE;
        end else begin
          eval_cnt_d = eval_cnt_q + EVAL_TIME_BITS'(1);
        end
      end
      ST_STORE: begin
        if (rep_cnt_q != REP_LAST) begin
          rep_cnt_d = rep_cnt_q + REPETITIONS_BITS'(1);
          state_d   = ST_RST;
        end else begin
          rep_cnt_d  = '0;
          loop_cnt_d = loop_cnt_q + SEL_W'(1);
          if (loop_cnt_q == LOOP_LAST) begin
            // Last loop done: the index is left on the final loop so
            // select_puf keeps showing it while idle.
            state_d = ST_DONE;
          end else begin
            if (loop_idx_q == LOOP_LAST) begin
              loop_idx_d = '0;
            end else begin
              loop_idx_d = loop_idx_q + SEL_W'(1);
            end
            state_d = ST_RST;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    done               = 1'b0;
    reset_puf          = 1'b0;
    enable_puf         = 1'b0;
    store_response_puf = 1'b0;
    case (state_q)
      ST_RST:   reset_puf          = 1'b1;
      ST_EVAL:  enable_puf         = 1'b1;
      ST_STORE: store_response_puf = 1'b1;
      ST_DONE:  done               = 1'b1;
      default:  done               = 1'b0;
    endcase
  end

  assign select_puf = loop_idx_q;

endmodule

// File: tb/tb_state_machine.sv
// Randomized scoreboard bench for state_machine with small parameters.
module tb_state_machine;

  localparam int N   = 6;
  localparam int R   = 2;
  localparam int E   = 3;
  localparam int CW  = 3;
  localparam int SW  = $clog2(N - 1) + 1;
  localparam int RUN = N * R * (E + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] challenge = '0;
  logic          done, reset_puf, enable_puf, store_response_puf;
  logic [SW-1:0] select_puf;

  always #5 clk = ~clk;

  state_machine #(
    .NUM_LOOPS(N), .REPETITIONS_BITS(16), .REPETITIONS(R),
    .EVAL_TIME_BITS(16), .EVAL_TIME(E), .CHALLENGE_BITS(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .done(done), .reset_puf(reset_puf), .select_puf(select_puf),
    .enable_puf(enable_puf), .store_response_puf(store_response_puf)
  );

  // kind: 0 = reset_puf pulse, 1 = store strobe, 2 = done pulse
  typedef struct {
    int kind;
    int sel;
    int t;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_fail = 0;
  int  next_free = 0;
  int  runs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: every loop from the start index in order, R evaluations each,
  // each evaluation E+2 cycles long, done right after the last store.
  function automatic void plan_run(input int k, input int ch);
    int c0;
    int base;
    c0 = (ch >= N) ? 0 : ch;
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < R; r++) begin
        base = k + (i * R + r) * (E + 2);
        exp_q.push_back('{kind: 0, sel: (c0 + i) % N, t: base});
        exp_q.push_back('{kind: 1, sel: (c0 + i) % N, t: base + E + 1});
      end
    end
    exp_q.push_back('{kind: 2, sel: (c0 + N - 1) % N, t: k + RUN});
  endfunction

  // One cycle of stimulus; decides from the model whether start is accepted.
  task automatic drive(input bit s, input int ch, input bit r);
    @(negedge clk);
    #2;
    if (r && !reset) begin
      reset = 1'b1;
      exp_q.delete();
      next_free = 32'h7fffffff;
      #1;
      check("async_reset_outputs", 32'({done, reset_puf, enable_puf, store_response_puf}), 32'd0);
      check("async_reset_sel", 32'(select_puf), 32'd0);
    end else if (!r && reset) begin
      reset = 1'b0;
      next_free = cyc + 1;
    end
    start = s;
    challenge = CW'(ch);
    if (s && !reset && (cyc + 1 >= next_free)) begin
      plan_run(cyc + 1, ch);
      next_free = cyc + 1 + RUN + 2;
      runs++;
    end
  endtask

  int  en_cnt = 0;
  bit  idle_chk = 1'b0;
  int  idle_sel = 0;
  int  m_kind;
  int  m_hot;
  ev_t m_ev;

  // Monitor: pops the expected event whenever the DUT pulses an output.
  always @(negedge clk) begin
    if (reset) begin
      en_cnt   = 0;
      idle_chk = 1'b0;
    end else begin
      m_hot = int'(reset_puf) + int'(enable_puf) + int'(store_response_puf) + int'(done);
      if (m_hot > 1) check("exclusive_outputs", 32'(m_hot), 32'd1);
      if (idle_chk) begin
        check("idle_sel_hold", 32'(select_puf), 32'(idle_sel));
        check("idle_outputs", 32'({done, reset_puf, enable_puf, store_response_puf}), 32'd0);
        idle_chk = 1'b0;
      end
      if (enable_puf) en_cnt++;
      if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        m_ev = exp_q.pop_front();
        check("missing_event", 32'(cyc), 32'(m_ev.t));
      end
      if (reset_puf || store_response_puf || done) begin
        m_kind = done ? 2 : (store_response_puf ? 1 : 0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(m_kind), 32'hffffffff);
        end else begin
          m_ev = exp_q.pop_front();
          check("event_kind", 32'(m_kind), 32'(m_ev.kind));
          check("event_sel", 32'(select_puf), 32'(m_ev.sel));
          check("event_cycle", 32'(cyc), 32'(m_ev.t));
          if (m_kind == 1) check("enable_len", 32'(en_cnt), 32'(E));
          if (m_kind == 0) en_cnt = 0;
          if (m_kind == 2) begin
            idle_chk = 1'b1;
            idle_sel = m_ev.sel;
          end
        end
      end
    end
  end

  int hold_cnt = 0;
  int rst_cnt = 0;
  bit s_v;

  initial begin
    #1;
    check("reset_outputs", 32'({done, reset_puf, enable_puf, store_response_puf}), 32'd0);
    check("reset_sel", 32'(select_puf), 32'd0);
    // Start toggled while in reset must be ignored.
    repeat (20) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1);
    repeat (10) drive(1'b0, 0, 1'b0);
    // Directed run aborted by reset during EVAL.
    drive(1'b1, 4, 1'b0);
    drive(1'b0, 0, 1'b0);
    for (int i = 0; i < 40 && !enable_puf; i++) drive(1'b0, 0, 1'b0);
    check("reached_eval", 32'(enable_puf), 32'd1);
    repeat (3) drive(1'b0, 0, 1'b1);
    repeat (3) drive(1'b0, 0, 1'b0);
    // Directed full runs: out-of-range challenge, then the top loop index.
    drive(1'b1, 7, 1'b0);
    repeat (RUN + 5) drive(1'b0, 0, 1'b0);
    drive(1'b1, N - 1, 1'b0);
    repeat (RUN + 5) drive(1'b0, 0, 1'b0);
    // Randomized phase with held start and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (hold_cnt > 0) begin
        s_v = 1'b1;
        hold_cnt--;
      end else begin
        s_v = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 199) == 0) hold_cnt = 150;
      end
      if (rst_cnt == 0 && $urandom_range(0, 599) == 0) rst_cnt = int'($urandom_range(1, 4));
      drive(s_v, int'($urandom_range(0, 7)), rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
    end
    for (int i = 0; i < RUN + 20 && (exp_q.size() > 0 || reset); i++) drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/state_machine.md
STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 The block SHALL have parameter NUM_LOOPS, default 1280: number of PUF loops swept per run.
REQ-002 The block SHALL have parameter REPETITIONS_BITS, default 16: width of the repetition counter.
REQ-003 The block SHALL have parameter REPETITIONS, default 2: evaluations per loop, >=1.
REQ-004 The block SHALL have parameter EVAL_TIME_BITS, default 16: width of the evaluation-time counter.
REQ-005 The block SHALL have parameter EVAL_TIME, default 8: enable_puf cycles per evaluation, >=1.
REQ-006 The block SHALL have parameter CHALLENGE_BITS, default 8: challenge width.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-010 The block SHALL have port challenge, input, CHALLENGE_BITS bits: starting loop index, latched on accepted start.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-012 The block SHALL have port reset_puf, output, 1 bit: clears the selected PUF loop and its counter.
REQ-013 The block SHALL have port select_puf, output, $clog2(NUM_LOOPS-1)+1 bits (12 at defaults): index of the loop under test.
REQ-014 The block SHALL have port enable_puf, output, 1 bit: lets the selected loop oscillate and count.
REQ-015 The block SHALL have port store_response_puf, output, 1 bit: one-cycle strobe to capture the loop response.

Function
REQ-016 The block SHALL implement states IDLE, RST, EVAL, STORE, DONE; outputs are Moore-decoded from the state register; select_puf is driven from a registered loop-index counter.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch challenge into the loop index, clear the repetition and loop counters, and enter RST; in other states start SHALL be ignored.
REQ-018 A latched challenge >= NUM_LOOPS SHALL set the starting index to 0.
REQ-019 RST SHALL last exactly 1 cycle with reset_puf=1, clear the eval counter, then enter EVAL.
REQ-020 EVAL SHALL last exactly EVAL_TIME cycles with enable_puf=1, then enter STORE.
REQ-021 STORE SHALL last exactly 1 cycle with store_response_puf=1.
REQ-022 After STORE, if the repetition count < REPETITIONS-1, it SHALL increment and the block SHALL re-enter RST with select_puf unchanged.
REQ-023 Otherwise the repetition count SHALL clear, the loop count SHALL increment, and the loop index SHALL increment, wrapping from NUM_LOOPS-1 to 0.
REQ-024 When the loop count reaches NUM_LOOPS, the block SHALL enter DONE instead of RST.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE; select_puf SHALL hold its last value in IDLE.
REQ-026 Every loop index SHALL be visited exactly once per run, in order starting from the latched challenge.
REQ-027 The run SHALL last NUM_LOOPS*REPETITIONS*(EVAL_TIME+2) cycles from the first RST cycle to the last STORE cycle, with done on the next cycle (25600 cycles at defaults).
REQ-028 reset_puf, enable_puf, store_response_puf and done SHALL be mutually exclusive and all 0 in IDLE.
REQ-029 Counter widths SHALL be REPETITIONS_BITS and EVAL_TIME_BITS, and terminal compares SHALL be exact equality (no overflow).

Reset
REQ-030 reset=1 SHALL immediately, without waiting for clk, force IDLE, all counters to 0, select_puf=0, and done, reset_puf, enable_puf, store_response_puf to 0.
REQ-031 reset asserted mid-run SHALL abort the run with no done pulse; start after release SHALL begin a fresh run.
REQ-032 While reset=1, start SHALL be ignored.

Verification
REQ-033 Scenario: reset 20 cycles, idle 10, start pulse 1 cycle, challenge=14 -> first RST with select_puf=14; done pulses once, 25601 cycles after the start edge.
REQ-034 Scenario: per evaluation -> reset_puf 1 cycle, enable_puf exactly 8 cycles, store_response_puf 1 cycle; each select_puf value is repeated twice.
REQ-035 Scenario: sweep order -> select_puf goes 14,15,...,1279,0,...,13; 2560 store strobes total; select_puf stays 13 in IDLE after done.
REQ-036 Scenario: reset asserted during EVAL -> outputs go to 0 asynchronously, state is IDLE, and no done pulse occurs.
REQ-037 Scenario: start held high or pulsed during a run -> ignored, with no restart or timing change; start held high through DONE begins a new run from IDLE.
REQ-038 Scenario: small parameters (NUM_LOOPS=3, REPETITIONS=1, EVAL_TIME=1), challenge=2 -> select_puf sequence 2,0,1; done 9 cycles after the first RST cycle.
